half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
- Registered, parameterizable bitwise half adder: per lane, s = a XOR b and c = a AND b.
- Outputs are captured on the rising clock edge.
- A valid flag travels alongside the data.
- A saturating counter records how many accepted lanes produced a carry.
- Used as a leaf arithmetic primitive, and as the reference block for adder-chain bring-up.

Parameters:
- WIDTH, 1: number of independent half-adder lanes (1..64).
- CNT_W, 16: width of the carry-event counter.
- REG_IN, 0: 1 inserts an input register stage, so latency becomes 2 cycles.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b are valid this cycle.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- clr_cnt  input  1  synchronous clear of carry_count.
- out_valid  output  1  s/c hold a valid result.
- s  output  WIDTH  per-lane sum bit (a^b).
- c  output  WIDTH  per-lane carry bit (a&b).
- carry_any  output  1  OR-reduction of c, qualified by out_valid.
- carry_count  output  CNT_W  saturating count of carry lanes accepted.

Behaviour:
- Reset: asserting rst_n low immediately forces s=0, c=0, out_valid=0, carry_any=0, carry_count=0 and clears any input-stage registers, independent of clk.
- Latency: 1 cycle with REG_IN=0, 2 cycles with REG_IN=1. Results appear on the edge(s) after in_valid=1.
- Data capture: s and c update only when the stage's valid is 1; otherwise they hold their previous value. out_valid follows the valid pipeline exactly, with no back-pressure.
- Lanes: each lane is fully independent, with no ripple between lanes. Truth table per lane: 00 gives s0 c0; 01 and 10 give s1 c0; 11 gives s0 c1.
- carry_any: registered with s/c, equal to |c when the captured valid is 1, else 0.
- carry_count:
  - On each cycle where the output stage captures valid data, add popcount(c_next) (0..WIDTH).
  - Saturate at 2^CNT_W-1 and never wrap.
  - clr_cnt=1 zeroes the counter on the next edge and takes priority over a simultaneous increment; the increment for that cycle is discarded.
- Reset mid-operation: in-flight data is dropped and no out_valid pulse is produced for it. After release, the first valid input behaves as in normal operation.
- Reset release: deassertion is synchronized externally. The block needs no internal synchronizer but must tolerate in_valid=1 on the first edge after release.
- X handling: a/b are ignored when in_valid=0, so X on a/b must not propagate to the outputs.

Decomposition:
- Shared package half_adder_pkg holds:
  - constant HA_MAX_WIDTH=64;
  - a function popcount over WIDTH bits, which also serves the counter;
  - a typedef for the count type, parameterized via CNT_W at the instance.
- One sub-module, ha_cell: a purely combinational 1-bit half adder (a, b to s, c), instantiated WIDTH times via generate.
- The top level contains the optional input register, the output register, the valid pipeline, carry_any and the saturating counter.

Test Plan:
- Reset: hold rst_n=0 with random a/b/in_valid -> s=0, c=0, out_valid=0, carry_count=0. Release, then apply in_valid=1 with a=1, b=1 -> one cycle later s=0, c=1, out_valid=1.
- WIDTH=1 truth table, 200 ns per vector (in_valid=1): a/b = 0/0, 0/1, 1/1, 1/0 -> s/c = 0/0, 1/0, 0/1, 1/0 respectively, each appearing 1 cycle after its input. carry_count=1 per captured 1/1 cycle.
- Hold behaviour: valid a=1, b=0 (s=1), then in_valid=0 with a=1, b=1 -> s stays 1, c stays 0, out_valid=0.
- WIDTH=8: a=8'hF0, b=8'hCC -> s=8'h3C, c=8'hC0, carry_any=1, carry_count +2.
- Saturation and clear: CNT_W=4, WIDTH=8, two valid cycles with a=b=8'hFF -> count=15 (saturated, not wrapped). Then clr_cnt=1 together with a valid a=b=8'hFF -> count=0.
- REG_IN=1 plus async reset mid-flight: inject valid data, assert rst_n low between the two stages -> outputs clear immediately and no out_valid pulse follows release.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half-adder block.
// Combinational helpers only; no state, no latency, no flow control.
// Callers zero-extend narrower vectors to HA_MAX_WIDTH before popcount.
package half_adder_pkg;

    localparam int HA_MAX_WIDTH = 64;
    localparam int HA_POP_W     = 7;

    function automatic logic [HA_POP_W-1:0] popcount(input logic [HA_MAX_WIDTH-1:0] v);
        logic [HA_POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < HA_MAX_WIDTH; i++) begin
            n = n + HA_POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ha_cell.sv
// Single-lane half adder: s = a ^ b, c = a & b.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered WIDTH-lane half adder with carry_any flag and saturating carry-lane counter.
// Latency 1 cycle (REG_IN=0) or 2 cycles (REG_IN=1) from in_valid to out_valid.
// No backpressure: every in_valid beat produces exactly one out_valid beat unless reset intervenes.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int CNT_W  = 16,
    parameter int REG_IN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic             carry_any,
    output logic [CNT_W-1:0] carry_count
);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;
    localparam int   SUM_W   = CNT_W + HA_POP_W;

    logic             stg_vld;
    logic [WIDTH-1:0] stg_a;
    logic [WIDTH-1:0] stg_b;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] c_next;
    logic [HA_POP_W-1:0] c_pop;
    logic [SUM_W-1:0]    cnt_sum;
    cnt_t                cnt_sat;

    generate
        if (REG_IN != 0) begin : g_in_reg
            logic             vld_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // Operands load only on valid beats so idle X never enters the pipe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                end else begin
                    vld_q <= in_valid;
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
            end

            assign stg_vld = vld_q;
            assign stg_a   = a_q;
            assign stg_b   = b_q;
        end else begin : g_no_in_reg
            assign stg_vld = in_valid;
            assign stg_a   = a;
            assign stg_b   = b;
        end
    endgenerate

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            ha_cell u_cell (
                .a (stg_a[i]),
                .b (stg_b[i]),
                .s (s_next[i]),
                .c (c_next[i])
            );
        end
    endgenerate

    assign c_pop = popcount(HA_MAX_WIDTH'(c_next));

    // Sum is wide enough that a full-lane add on a saturated count cannot overflow.
    always_comb begin
        cnt_sum = {{HA_POP_W{1'b0}}, carry_count} + SUM_W'(c_pop);
        cnt_sat = cnt_sum[CNT_W-1:0];
        if (cnt_sum > SUM_W'(CNT_MAX)) begin
            cnt_sat = CNT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c         <= '0;
            carry_any <= 1'b0;
        end else begin
            out_valid <= stg_vld;
            carry_any <= stg_vld & (|c_next);
            if (stg_vld) begin
                s <= s_next;
                c <= c_next;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_count <= '0;
        end else if (clr_cnt) begin
            carry_count <= '0;
        end else if (stg_vld) begin
            carry_count <= cnt_sat;
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder across several parameterisations.
// All instances share stimulus; each task checks the instance relevant to its feature.
module tb_half_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_cnt;

    int checks;
    int passed;

    // u1: WIDTH=1; u8: WIDTH=8 CNT_W=16; us: WIDTH=8 CNT_W=4; ur: WIDTH=8 REG_IN=1
    logic        u1_ov, u1_s, u1_c, u1_any;
    logic [15:0] u1_cnt;
    logic        u8_ov, u8_any;
    logic [7:0]  u8_s, u8_c;
    logic [15:0] u8_cnt;
    logic        us_ov, us_any;
    logic [7:0]  us_s, us_c;
    logic [3:0]  us_cnt;
    logic        ur_ov, ur_any;
    logic [7:0]  ur_s, ur_c;
    logic [15:0] ur_cnt;

    half_adder #(.WIDTH(1), .CNT_W(16), .REG_IN(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0]), .b(b[0]),
        .clr_cnt(clr_cnt), .out_valid(u1_ov), .s(u1_s), .c(u1_c),
        .carry_any(u1_any), .carry_count(u1_cnt));

    half_adder #(.WIDTH(8), .CNT_W(16), .REG_IN(0)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .clr_cnt(clr_cnt), .out_valid(u8_ov), .s(u8_s), .c(u8_c),
        .carry_any(u8_any), .carry_count(u8_cnt));

    half_adder #(.WIDTH(8), .CNT_W(4), .REG_IN(0)) us (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .clr_cnt(clr_cnt), .out_valid(us_ov), .s(us_s), .c(us_c),
        .carry_any(us_any), .carry_count(us_cnt));

    half_adder #(.WIDTH(8), .CNT_W(16), .REG_IN(1)) ur (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .clr_cnt(clr_cnt), .out_valid(ur_ov), .s(ur_s), .c(ur_c),
        .carry_any(ur_any), .carry_count(ur_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0; a = '0; b = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
        end
        @(negedge clk);
        checks++; if (u8_s !== 8'h00) $display("FAIL reset_s got=%h exp=00", u8_s); else passed++;
        checks++; if (u8_c !== 8'h00) $display("FAIL reset_c got=%h exp=00", u8_c); else passed++;
        checks++; if ({u1_ov, u8_ov, us_ov, ur_ov} !== 4'b0000) $display("FAIL reset_ov got=%b exp=0000", {u1_ov, u8_ov, us_ov, ur_ov}); else passed++;
        checks++; if (u8_cnt !== 16'd0 || u8_any !== 1'b0) $display("FAIL reset_cnt got=%0d any=%b exp=0/0", u8_cnt, u8_any); else passed++;
        // valid on the very first edge after release
        rst_n = 1'b1; in_valid = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({u1_ov, u1_s, u1_c} !== 3'b101) $display("FAIL first_after_reset got ov/s/c=%b exp=101", {u1_ov, u1_s, u1_c}); else passed++;
        checks++; if (u1_cnt !== 16'd1) $display("FAIL first_after_reset_cnt got=%0d exp=1", u1_cnt); else passed++;
    endtask

    task automatic test_truth_table();
        logic [1:0] vec_ab [4];
        logic [1:0] exp_sc [4];
        vec_ab = '{2'b00, 2'b01, 2'b11, 2'b10};
        exp_sc = '{2'b00, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = {7'd0, vec_ab[i][1]}; b = {7'd0, vec_ab[i][0]}; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({u1_ov, u1_s, u1_c} !== {1'b1, exp_sc[i]})
                $display("FAIL truth_%0d got ov/s/c=%b exp=%b", i, {u1_ov, u1_s, u1_c}, {1'b1, exp_sc[i]});
            else passed++;
            repeat (19) @(negedge clk);
        end
        checks++; if (u1_cnt !== 16'd1) $display("FAIL truth_cnt got=%0d exp=1", u1_cnt); else passed++;
    endtask

    task automatic test_hold();
        do_reset();
        a = 8'h01; b = 8'h00; in_valid = 1'b1;
        @(negedge clk);
        a = 8'h01; b = 8'h01; in_valid = 1'b0;
        @(negedge clk);
        checks++; if ({u1_ov, u1_s, u1_c} !== 3'b010) $display("FAIL hold got ov/s/c=%b exp=010", {u1_ov, u1_s, u1_c}); else passed++;
        a = 8'bx; b = 8'bx;
        @(negedge clk);
        checks++; if ({u1_s, u1_c, u8_s, u8_c} !== 18'b10_0000_0001_0000_0000) $display("FAIL hold_x got s/c=%b %h %h exp=10 01 00", {u1_s, u1_c}, u8_s, u8_c); else passed++;
        checks++; if ({u8_any, ur_any, ur_ov} !== 3'b000 || u8_cnt !== 16'd0) $display("FAIL hold_x_flags got=%b cnt=%0d exp=000/0", {u8_any, ur_any, ur_ov}, u8_cnt); else passed++;
        a = '0; b = '0;
    endtask

    task automatic test_width8();
        do_reset();
        a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (u8_s !== 8'h3C || u8_c !== 8'hC0) $display("FAIL w8_sc got s=%h c=%h exp=3c/c0", u8_s, u8_c); else passed++;
        checks++; if (u8_any !== 1'b1 || u8_cnt !== 16'd2) $display("FAIL w8_any_cnt got=%b/%0d exp=1/2", u8_any, u8_cnt); else passed++;
        @(negedge clk);
        checks++; if (u8_any !== 1'b0 || u8_ov !== 1'b0 || u8_c !== 8'hC0) $display("FAIL w8_idle got any=%b ov=%b c=%h exp=0/0/c0", u8_any, u8_ov, u8_c); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        checks++; if (us_cnt !== 4'd8) $display("FAIL sat_first got=%0d exp=8", us_cnt); else passed++;
        @(negedge clk);
        checks++; if (us_cnt !== 4'd15 || u8_cnt !== 16'd16) $display("FAIL sat_second got=%0d/%0d exp=15/16", us_cnt, u8_cnt); else passed++;
        @(negedge clk);
        checks++; if (us_cnt !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", us_cnt); else passed++;
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        checks++; if (us_cnt !== 4'd0 || u8_cnt !== 16'd0) $display("FAIL clr_priority got=%0d/%0d exp=0/0", us_cnt, u8_cnt); else passed++;
        a = 8'h03; b = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (us_cnt !== 4'd1 || us_s !== 8'h02) $display("FAIL after_clr got cnt=%0d s=%h exp=1/02", us_cnt, us_s); else passed++;
    endtask

    task automatic test_reg_in_reset();
        do_reset();
        a = 8'h0F; b = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        checks++; if (ur_ov !== 1'b0) $display("FAIL regin_lat1 got ov=%b exp=0", ur_ov); else passed++;
        a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({ur_ov, ur_any} !== 2'b11 || ur_s !== 8'hF0 || ur_c !== 8'h0F || ur_cnt !== 16'd4)
            $display("FAIL regin_lat2 got ov/any=%b s=%h c=%h cnt=%0d exp=11/f0/0f/4", {ur_ov, ur_any}, ur_s, ur_c, ur_cnt);
        else passed++;
        // second beat is now in the input stage
        rst_n = 1'b0;
        #1;
        checks++; if ({ur_ov, ur_any} !== 2'b00 || ur_s !== 8'h00 || ur_c !== 8'h00 || ur_cnt !== 16'd0)
            $display("FAIL regin_async_rst got ov/any=%b s=%h c=%h cnt=%0d exp=00/00/00/0", {ur_ov, ur_any}, ur_s, ur_c, ur_cnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ur_ov !== 1'b0) $display("FAIL regin_no_pulse_%0d got ov=%b exp=0", i, ur_ov); else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_truth_table();
        test_hold();
        test_width8();
        test_saturation();
        test_reg_in_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
